motor_step_ctrl: RTL

MOTOR_STEP_CTRL -- requirements
Module: motor_step_ctrl

---
 rtl/motor_step_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/motor_step_ctrl.sv
// Wishbone-controlled stepper sequencer: programmable step period, step count,
// direction and half/full stepping, with a sticky DONE flag and level interrupt.
module motor_step_ctrl #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned STEP_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [3:0]  motor_o,
  output logic        busy_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_ack;
  logic [3:0]          r_ctrl, w_ctrl_nxt;
  logic [DIV_W-1:0]    r_div, w_div_nxt, r_timer, w_timer_nxt, w_reload;
  logic [STEP_W-1:0]   r_steps, w_steps_nxt, r_remaining, w_rem_nxt;
  logic [2:0]          r_index, w_index_nxt, w_inc;
  logic                r_done, w_done_nxt, w_done_set, w_clr_done;
  logic [3:0]          r_motor;
  logic                r_irq;
  logic                w_wr, w_start, w_abort;
  logic [31:0]         w_rdata;
  logic                w_unused_adr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return 4'b0001;
      3'd1:    return 4'b0011;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0100;
      3'd5:    return 4'b1100;
      3'd6:    return 4'b1000;
      default: return 4'b1001;
    endcase
  endfunction

  assign w_unused_adr = &{wbs_adr_i[31:4], wbs_adr_i[1:0]};

  // Register writes land in the ack cycle
  always_comb begin
    w_wr        = r_ack & wbs_cyc_i & wbs_stb_i & wbs_we_i;
    w_ctrl_nxt  = r_ctrl;
    w_div_nxt   = r_div;
    w_steps_nxt = r_steps;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_clr_done  = 1'b0;
    if (w_wr) begin
      case (wbs_adr_i[3:2])
        2'd0: if (wbs_sel_i[0]) begin
          w_ctrl_nxt = wbs_dat_i[3:0];
          w_start    = wbs_dat_i[4];
          w_abort    = wbs_dat_i[5];
        end
        2'd1: w_div_nxt   = DIV_W'(merge_bytes(32'(r_div), wbs_dat_i, wbs_sel_i));
        2'd2: w_steps_nxt = STEP_W'(merge_bytes(32'(r_steps), wbs_dat_i, wbs_sel_i));
        default: w_clr_done = wbs_sel_i[0] & wbs_dat_i[1];
      endcase
    end
  end

  assign w_reload = (r_div == '0) ? DIV_W'(1) : r_div;
  assign w_inc    = r_ctrl[2] ? 3'd1 : 3'd2;

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_timer_nxt = r_timer;
    w_index_nxt = r_index;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && w_ctrl_nxt[0]) begin
          if (r_steps != '0) begin
            w_state_nxt = ST_RUN;
            w_rem_nxt   = r_steps;
            w_timer_nxt = w_reload;
            if (!w_ctrl_nxt[2]) w_index_nxt = {r_index[2:1], 1'b0};
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end
      end
      ST_RUN: begin
        if (w_abort || !w_ctrl_nxt[0]) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer <= DIV_W'(1)) begin
          w_index_nxt = r_ctrl[1] ? (r_index - w_inc) : (r_index + w_inc);
          w_rem_nxt   = r_remaining - STEP_W'(1);
          w_timer_nxt = w_reload;
          if (r_remaining == STEP_W'(1)) w_state_nxt = ST_FINISH;
        end else begin
          w_timer_nxt = r_timer - DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_done_set  = 1'b1;
      end
    endcase
    w_done_nxt = w_done_set ? 1'b1 : (w_clr_done ? 1'b0 : r_done);
  end

  // Pads and irq are registered from next-state values so they change on the
  // same edge as the index/DONE they reflect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ack       <= 1'b0;
      r_ctrl      <= '0;
      r_div       <= '0;
      r_steps     <= '0;
      r_remaining <= '0;
      r_timer     <= '0;
      r_index     <= '0;
      r_done      <= 1'b0;
      r_motor     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= wbs_cyc_i & wbs_stb_i & ~r_ack;
      r_ctrl      <= w_ctrl_nxt;
      r_div       <= w_div_nxt;
      r_steps     <= w_steps_nxt;
      r_remaining <= w_rem_nxt;
      r_timer     <= w_timer_nxt;
      r_index     <= w_index_nxt;
      r_done      <= w_done_nxt;
      r_motor     <= w_ctrl_nxt[0] ? phase_of(w_index_nxt) : '0;
      r_irq       <= w_done_nxt & w_ctrl_nxt[3];
    end
  end

  always_comb begin
    case (wbs_adr_i[3:2])
      2'd0:    w_rdata = {28'd0, r_ctrl};
      2'd1:    w_rdata = 32'(r_div);
      2'd2:    w_rdata = 32'(r_steps);
      default: w_rdata = {16'(r_remaining), 11'd0, r_index, r_done, busy_o};
    endcase
  end

  assign busy_o    = (r_state != ST_IDLE);
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_ack ? w_rdata : '0;
  assign motor_o   = r_motor;
  assign irq_o     = r_irq;

endmodule
